// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, mul/div result stream,
// RF write outputs and hazard-unit pending queries.
interface wb_port_arbiter_if #(
  parameter int word_width = 32
);
  logic                  RegWriteW;
  logic [4:0]            RdW;
  logic [word_width-1:0] ResultW;
  logic                  MdValid;
  logic [4:0]            MdRd;
  logic [word_width-1:0] MdResult;
  logic                  MdReady;
  logic                  RegWriteRF;
  logic [4:0]            RdRF;
  logic [word_width-1:0] WDRF;
  logic                  GrantMd;
  logic [4:0]            QueryRs1;
  logic [4:0]            QueryRs2;
  logic                  PendingRs1;
  logic                  PendingRs2;
  logic                  StallReq;

  // Mul/div handshake: a result transfers on any cycle where MdValid && MdReady.
  modport master (
    output RegWriteW, RdW, ResultW, MdValid, MdRd, MdResult, QueryRs1, QueryRs2,
    input  MdReady, RegWriteRF, RdRF, WDRF, GrantMd, PendingRs1, PendingRs2, StallReq
  );

  modport slave (
    input  RegWriteW, RdW, ResultW, MdValid, MdRd, MdResult, QueryRs1, QueryRs2,
    output MdReady, RegWriteRF, RdRF, WDRF, GrantMd, PendingRs1, PendingRs2, StallReq
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the RF write port between pipeline writeback (always wins) and a small
// FIFO of out-of-band mul/div results that drain into idle writeback slots.
module wb_port_arbiter #(
  parameter int word_width   = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  wb_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [DEPTH-1:0]      live_q, live_d;
  logic [4:0]            rd_q   [DEPTH];
  logic [4:0]            rd_d   [DEPTH];
  logic [word_width-1:0] data_q [DEPTH];
  logic [word_width-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [SC_W-1:0]       starve_q, starve_d;
  logic                  stall_req_q, stall_req_d;

  logic fifo_full, not_empty, head_live, any_live;
  logic pipe_wr, grant, pop, push;

  always_comb begin
    fifo_full = (count_q == CNT_W'(DEPTH));
    not_empty = (count_q != '0);
    head_live = not_empty && live_q[rd_ptr_q];
    any_live  = |live_q;
    pipe_wr   = bus.RegWriteW && (bus.RdW != 5'd0);
    grant     = !pipe_wr && head_live;
    // A dead head is discarded without touching the RF, even under a pipeline write.
    pop       = not_empty && (grant || !live_q[rd_ptr_q]);
    push      = bus.MdValid && !fifo_full && (bus.MdRd != 5'd0);
  end

  always_comb begin
    live_d = live_q;
    rd_d   = rd_q;
    data_d = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_wr && live_q[i] && (rd_q[i] == bus.RdW)) live_d[i] = 1'b0;
    end
    if (pop) live_d[rd_ptr_q] = 1'b0;
    // Applied after the kill so a result enqueued alongside a same-rd write survives.
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
      rd_d[wr_ptr_q]   = bus.MdRd;
      data_d[wr_ptr_q] = bus.MdResult;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    if (grant || !any_live) begin
      starve_d = '0;
    end else if (head_live && pipe_wr && (starve_q != SC_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + SC_W'(1);
    end else begin
      starve_d = starve_q;
    end
    stall_req_d = (starve_d >= SC_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      stall_req_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      live_q      <= live_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      stall_req_q <= stall_req_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    bus.MdReady    = !fifo_full;
    bus.StallReq   = stall_req_q;
    bus.GrantMd    = grant;
    bus.RegWriteRF = 1'b0;
    bus.RdRF       = 5'd0;
    bus.WDRF       = '0;
    if (pipe_wr) begin
      bus.RegWriteRF = 1'b1;
      bus.RdRF       = bus.RdW;
      bus.WDRF       = bus.ResultW;
    end else if (grant) begin
      bus.RegWriteRF = 1'b1;
      bus.RdRF       = rd_q[rd_ptr_q];
      bus.WDRF       = data_q[rd_ptr_q];
    end
  end

  // Only live entries are reported; the in-flight incoming result is not.
  always_comb begin
    bus.PendingRs1 = 1'b0;
    bus.PendingRs2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (rd_q[i] == bus.QueryRs1) && (bus.QueryRs1 != 5'd0)) bus.PendingRs1 = 1'b1;
      if (live_q[i] && (rd_q[i] == bus.QueryRs2) && (bus.QueryRs2 != 5'd0)) bus.PendingRs2 = 1'b1;
    end
  end
endmodule
